tt_um_2x2_matrix_mult_vort3xed: RTL and testbench
=================================================

Name: tt_um_2x2_matrix_mult_vort3xed

Overview:
- TinyTapeout user tile that computes C = A x B for two 2x2 matrices of 8-bit unsigned elements.
- Elements are streamed in one byte per strobe on ui_in. A small FSM then computes one C element per cycle.
- Results are 17-bit unsigned and are read byte-wise on uo_out through a combinational select driven from uio_in.
- Sits directly under the TinyTapeout top-level harness.

Parameters:
- None. Element width is fixed at 8 bits and result width at 17 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  tile enable. When low, strobes (valid, restart) are ignored and state holds.
- ui_in  in  8  data byte, one matrix element, unsigned.
- uio_in  in  8  control inputs:
  - [0] valid: load strobe.
  - [2:1] csel: result element select. 0=C00, 1=C01, 2=C10, 3=C11.
  - [4:3] bsel: byte select. 0=bits[7:0], 1=bits[15:8], 2={7'b0,bit16}, 3=status byte.
  - [5] restart.
  - [7:6] unused.
- uo_out  out  8  selected result byte or status byte.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all uio pins are inputs).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State LOAD, load count 0.
  - All A/B element registers 0; all C registers 0.
  - done and busy 0.
  - uo_out then shows 0 for every selection except the status byte, which is also 0.
- Load order: A00, A01, A10, A11, B00, B01, B10, B11.
- LOAD state:
  - Each rising edge with ena=1 and valid=1 stores ui_in into the element indexed by the count, and the count increments.
  - The edge that stores the 8th element (B11) moves the FSM to COMPUTE with index 0; the count stays at 8.
  - valid held high for N cycles loads N elements; there is no edge detection.
- COMPUTE state:
  - Each edge writes one result, in order C00, C01, C10, C11: Cij = Ai0*B0j + Ai1*B1j.
  - Each result is computed as a 17-bit unsigned sum of two 16-bit products, with no truncation.
  - The edge writing C11 moves the FSM to DONE.
  - Timing: if B11 loads at edge k, C00 is written at k+1 and C11 at k+4; done=1 is visible after edge k+4.
  - valid is ignored in COMPUTE.
- DONE state:
  - Results hold; valid is ignored.
- restart (ena=1, sampled on the edge):
  - Valid in any state: go to LOAD, count 0, done 0.
  - A, B and C registers keep their values; C is overwritten by the next computation.
  - restart has priority over valid in the same cycle; that byte is not loaded.
- Status byte:
  - bit0 = done (1 only in DONE).
  - bit1 = busy (1 only in COMPUTE).
  - bits[5:2] = load count, 0..8.
  - bits[7:6] = 0.
- uo_out is purely combinational from the registers and csel/bsel, so readout has zero latency. During COMPUTE, not-yet-written C elements show their previous values.
- Reset asserted mid-load or mid-compute aborts immediately to the reset state.
- ena low freezes all registers; outputs still reflect the current register contents.

Test Plan:
- Basic product: reset, load A=[[1,2],[3,4]], B=[[5,6],[7,8]], wait 4 cycles.
  -> status=0x21 (done, count 8).
  -> C00=19, C01=22, C10=43, C11=50.
  -> bsel=1 and bsel=2 read 0 for every element.
- Overflow width: load all elements 255.
  -> every Cij byte0=0x02, byte1=0xFC, byte2=0x01 (130050).
- Identity: A=I, B=[[9,200],[17,128]] -> C equals B.
  - Check status busy=1 (0x22) during the 4 compute cycles, then 0x21.
- Restart mid-load: load 5 elements, assert restart, then load a fresh 8 elements.
  -> results correspond to the fresh 8 only; status count reads 5 then 0.
- ena gating and reset:
  - With ena=0, apply valid for 3 cycles -> count stays 0.
  - Assert rst_n low during COMPUTE (asynchronously, between edges) -> status=0x00 and all C bytes 0 immediately.

Source files
------------

// File: rtl/tt_um_2x2_matrix_mult_vort3xed.sv
// rtl/tt_um_2x2_matrix_mult_vort3xed.sv - 2x2 unsigned 8-bit matrix multiplier tile
// Elements load byte-serially; one C element is computed per cycle; results are read byte-wise.
module tt_um_2x2_matrix_mult_vort3xed (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  a_q [4];
  logic [7:0]  a_d [4];
  logic [7:0]  b_q [4];
  logic [7:0]  b_d [4];
  logic [16:0] c_q [4];
  logic [16:0] c_d [4];

  logic        valid, restart;
  logic [1:0]  csel, bsel;
  logic        done, busy;
  logic [7:0]  status;
  logic [15:0] prod0, prod1;
  logic [16:0] dot;
  logic        unused_uio;

  assign valid   = uio_in[0];
  assign csel    = uio_in[2:1];
  assign bsel    = uio_in[4:3];
  assign restart = uio_in[5];
  assign unused_uio = &{1'b0, uio_in[7:6]};

  assign done   = (state_q == ST_DONE);
  assign busy   = (state_q == ST_COMPUTE);
  assign status = {2'b00, count_q, busy, done};

  // Row of A selected by idx[1], column of B by idx[0]
  assign prod0 = {8'd0, a_q[{idx_q[1], 1'b0}]} * {8'd0, b_q[{1'b0, idx_q[0]}]};
  assign prod1 = {8'd0, a_q[{idx_q[1], 1'b1}]} * {8'd0, b_q[{1'b1, idx_q[0]}]};
  assign dot   = {1'b0, prod0} + {1'b0, prod1};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    if (ena) begin
      if (restart) begin
        state_d = ST_LOAD;
        count_d = 4'd0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (valid) begin
              if (!count_q[2]) a_d[count_q[1:0]] = ui_in;
              else             b_d[count_q[1:0]] = ui_in;
              count_d = count_q + 4'd1;
              if (count_q == 4'd7) begin
                state_d = ST_COMPUTE;
                idx_d   = 2'd0;
              end
            end
          end
          ST_COMPUTE: begin
            c_d[idx_q] = dot;
            idx_d      = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      count_q <= 4'd0;
      idx_q   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= 8'd0;
        b_q[i] <= 8'd0;
        c_q[i] <= 17'd0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    case (bsel)
      2'd0:    uo_out = c_q[csel][7:0];
      2'd1:    uo_out = c_q[csel][15:8];
      2'd2:    uo_out = {7'd0, c_q[csel][16]};
      default: uo_out = status;
    endcase
  end

  assign uio_out = 8'd0;
  assign uio_oe  = 8'd0;

endmodule

// File: tb/tb_tt_um_2x2_matrix_mult_vort3xed.sv
// tb/tb_tt_um_2x2_matrix_mult_vort3xed.sv - bench for the 2x2 matrix multiplier tile
// Directed and random matrices checked against a plain-arithmetic matrix product.
module tb_tt_um_2x2_matrix_mult_vort3xed;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  int ma [4];
  int mb [4];
  int mc [4];

  tt_um_2x2_matrix_mult_vort3xed dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic read(input int c, input int b, output logic [7:0] v);
    uio_in = {3'b000, b[1:0], c[1:0], 1'b0};
    #1;
    v = uo_out;
  endtask

  task automatic chk_status(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    read(0, 3, v);
    chk(tag, v, exp);
  endtask

  // Reference: Cij = sum_k Aik*Bkj with unbounded integer arithmetic
  task automatic model();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        mc[i*2+j] = ma[i*2]*mb[j] + ma[i*2+1]*mb[2+j];
  endtask

  task automatic load_all();
    for (int n = 0; n < 8; n++) begin
      ui_in  = (n < 4) ? ma[n][7:0] : mb[n-4][7:0];
      uio_in = 8'h01;
      step();
    end
    uio_in = 8'h00;
  endtask

  task automatic pulse_restart();
    uio_in = 8'h20;
    step();
    uio_in = 8'h00;
  endtask

  task automatic chk_results(input string tag);
    logic [7:0] v;
    int e;
    model();
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 3; b++) begin
        e = (b == 0) ? (mc[c] & 255) : (b == 1) ? ((mc[c] >> 8) & 255) : ((mc[c] >> 16) & 1);
        read(c, b, v);
        chk($sformatf("%s_c%0d_b%0d", tag, c, b), v, e[7:0]);
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #12;
    chk_status("reset_status", 8'h00);
    for (int c = 0; c < 4; c++) begin
      read(c, 0, v); chk("reset_c_lo", v, 8'h00);
    end
    chk("uio_oe", uio_oe, 8'h00);
    chk("uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    step();

    ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8};
    load_all();
    repeat (4) step();
    chk_status("basic_status", 8'h21);
    chk_results("basic");

    pulse_restart();
    ma = '{255, 255, 255, 255}; mb = '{255, 255, 255, 255};
    load_all();
    repeat (4) step();
    chk_results("ovf");

    pulse_restart();
    ma = '{1, 0, 0, 1}; mb = '{9, 200, 17, 128};
    load_all();
    chk_status("id_busy0", 8'h22);
    for (int k = 1; k < 4; k++) begin
      step();
      chk_status($sformatf("id_busy%0d", k), 8'h22);
    end
    step();
    chk_status("id_done", 8'h21);
    chk_results("ident");

    for (int t = 0; t < 6; t++) begin
      pulse_restart();
      for (int n = 0; n < 4; n++) begin
        ma[n] = int'($urandom_range(0, 255));
        mb[n] = int'($urandom_range(0, 255));
      end
      load_all();
      repeat (4) step();
      chk_status($sformatf("rnd%0d_status", t), 8'h21);
      chk_results($sformatf("rnd%0d", t));
    end

    pulse_restart();
    for (int n = 0; n < 5; n++) begin
      ui_in = 8'hEE; uio_in = 8'h01; step();
    end
    uio_in = 8'h00;
    chk_status("mid_count5", 8'h14);
    ui_in = 8'hEE; uio_in = 8'h21;
    step();
    uio_in = 8'h00;
    chk_status("restart_count0", 8'h00);
    ma = '{10, 20, 30, 40}; mb = '{50, 60, 70, 80};
    load_all();
    repeat (4) step();
    chk_results("fresh");

    pulse_restart();
    ena = 1'b0;
    ui_in = 8'h33; uio_in = 8'h01;
    repeat (3) step();
    uio_in = 8'h00;
    chk_status("ena_low_count", 8'h00);
    ena = 1'b1;

    load_all();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("async_rst_status", 8'h00);
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 3; b++) begin
        read(c, b, v);
        chk($sformatf("async_rst_c%0d_b%0d", c, b), v, 8'h00);
      end
    end
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
